// File: rtl/block_filter_ctrl.sv
// block_filter_ctrl: frame scheduler for the 5-parallel block_filter datapath.
// It collects a serial frame of N = 5*FRAME_BLOCKS samples and clears the filter.
// It then streams the frame through the filter one block per clock and flushes
// the filter pipeline. Results are captured in place, and the filtered frame is
// returned as a valid/ready stream.
// Optional feature: define BLOCK_FILTER_CTRL_BYPASS_EN to add the `bypass` input.
// When `bypass` is high on leaving LOAD, the frame skips filtering and is
// returned unchanged.
module block_filter_ctrl #(
    parameter int DW           = 16,
    parameter int FRAME_BLOCKS = 200,
    parameter int LAT          = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          flt_reset,
    output logic [DW-1:0] flt_in0,
    output logic [DW-1:0] flt_in_1,
    output logic [DW-1:0] flt_in_2,
    output logic [DW-1:0] flt_in_3,
    output logic [DW-1:0] flt_in_4,
    input  logic [DW-1:0] flt_out0,
    input  logic [DW-1:0] flt_out_1,
    input  logic [DW-1:0] flt_out_2,
    input  logic [DW-1:0] flt_out_3,
    input  logic [DW-1:0] flt_out_4,
`ifdef BLOCK_FILTER_CTRL_BYPASS_EN
    input  logic          bypass,
`endif
    output logic          busy,
    output logic          frame_done
);

    localparam int AW = (FRAME_BLOCKS > 1) ? $clog2(FRAME_BLOCKS) : 1;
    localparam int CW = $clog2(FRAME_BLOCKS + LAT + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_PRIME,
        S_RUN,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t               r_state;
    logic [2:0]           r_wrBank;
    logic [AW-1:0]        r_wrAddr;
    logic [CW-1:0]        r_blkCnt;
    logic [2:0]           r_rdBank;
    logic [AW-1:0]        r_rdAddr;
    logic [4:0][DW-1:0]   r_fltIn;
    logic                 r_frameDone;
    logic [DW-1:0]        r_mem [5][FRAME_BLOCKS];

    logic                 w_bypass;
    logic                 w_inFire;
    logic                 w_lastIn;
    logic                 w_lastOut;
    logic                 w_runLast;
    logic                 w_flushLast;
    logic                 w_capture;
    logic [AW-1:0]        w_capAddr;
    logic [AW-1:0]        w_rdBlkAddr;
    logic [4:0][DW-1:0]   w_fltOut;

`ifdef BLOCK_FILTER_CTRL_BYPASS_EN
    assign w_bypass = bypass;
`else
    assign w_bypass = 1'b0;
`endif

    // Bank b holds sample 5k+b, so bank 0 pairs with lane 4 (oldest) and bank 4 with lane 0 (newest).
    assign w_fltOut[0] = flt_out_4;
    assign w_fltOut[1] = flt_out_3;
    assign w_fltOut[2] = flt_out_2;
    assign w_fltOut[3] = flt_out_1;
    assign w_fltOut[4] = flt_out0;

    assign flt_in_4 = r_fltIn[0];
    assign flt_in_3 = r_fltIn[1];
    assign flt_in_2 = r_fltIn[2];
    assign flt_in_1 = r_fltIn[3];
    assign flt_in0  = r_fltIn[4];

    assign w_inFire    = (r_state == S_LOAD) && s_valid;
    assign w_lastIn    = (r_wrBank == 3'd4) && (r_wrAddr == AW'(FRAME_BLOCKS - 1));
    assign w_lastOut   = (r_rdBank == 3'd4) && (r_rdAddr == AW'(FRAME_BLOCKS - 1));
    assign w_runLast   = (r_blkCnt == CW'(FRAME_BLOCKS - 1));
    assign w_flushLast = (r_blkCnt == CW'(FRAME_BLOCKS + LAT - 1));
    assign w_capture   = ((r_state == S_RUN) || (r_state == S_FLUSH)) && (r_blkCnt >= CW'(LAT));
    assign w_capAddr   = AW'(r_blkCnt - CW'(LAT));
    assign w_rdBlkAddr = AW'(r_blkCnt);

    assign s_ready    = (r_state == S_LOAD) && !reset;
    assign m_valid    = (r_state == S_DRAIN);
    assign m_last     = (r_state == S_DRAIN) && w_lastOut;
    assign busy       = (r_state == S_PRIME) || (r_state == S_RUN) || (r_state == S_FLUSH);
    assign flt_reset  = reset || (r_state == S_PRIME);
    assign frame_done = r_frameDone;

    // Output sample is only presented in DRAIN, so the port reads zero in every other state
    always_comb begin
        m_data = '0;
        if (r_state == S_DRAIN) begin
            m_data = r_mem[r_rdBank][r_rdAddr];
        end
    end

    // Frame storage: input samples land here, and filter results overwrite them in place
    always_ff @(posedge clk) begin
        if (w_inFire) begin
            r_mem[r_wrBank][r_wrAddr] <= s_data;
        end else if (w_capture) begin
            for (int b = 0; b < 5; b++) begin
                r_mem[b][w_capAddr] <= w_fltOut[b];
            end
        end
    end

    // Frame sequencer: LOAD -> PRIME -> RUN -> FLUSH -> DRAIN -> LOAD, with filter-block and pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_LOAD;
            r_wrBank    <= '0;
            r_wrAddr    <= '0;
            r_blkCnt    <= '0;
            r_rdBank    <= '0;
            r_rdAddr    <= '0;
            r_fltIn     <= '0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (s_valid) begin
                        if (w_lastIn) begin
                            r_wrBank <= '0;
                            r_wrAddr <= '0;
                            r_blkCnt <= '0;
                            r_rdBank <= '0;
                            r_rdAddr <= '0;
                            r_state  <= w_bypass ? S_DRAIN : S_PRIME;
                        end else if (r_wrBank == 3'd4) begin
                            r_wrBank <= '0;
                            r_wrAddr <= r_wrAddr + 1'b1;
                        end else begin
                            r_wrBank <= r_wrBank + 1'b1;
                        end
                    end
                end
                S_PRIME: begin
                    r_blkCnt <= '0;
                    r_fltIn  <= '0;
                    r_state  <= S_RUN;
                end
                S_RUN: begin
                    for (int b = 0; b < 5; b++) begin
                        r_fltIn[b] <= r_mem[b][w_rdBlkAddr];
                    end
                    r_blkCnt <= r_blkCnt + 1'b1;
                    if (w_runLast) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    r_fltIn  <= '0;
                    r_blkCnt <= r_blkCnt + 1'b1;
                    if (w_flushLast) begin
                        r_rdBank <= '0;
                        r_rdAddr <= '0;
                        r_state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (m_ready) begin
                        if (w_lastOut) begin
                            r_rdBank    <= '0;
                            r_rdAddr    <= '0;
                            r_frameDone <= 1'b1;
                            r_state     <= S_LOAD;
                        end else if (r_rdBank == 3'd4) begin
                            r_rdBank <= '0;
                            r_rdAddr <= r_rdAddr + 1'b1;
                        end else begin
                            r_rdBank <= r_rdBank + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_filter_ctrl.sv
// Testbench for block_filter_ctrl. A small stand-in for block_filter is included.
// It has one register stage, giving LAT=2, and either identity taps or
// y[n] = x[n] + (x[n-1] >> 1). Define BLOCK_FILTER_CTRL_BYPASS_EN to build
// against the bypass variant.
module tb_block_filter_ctrl;

    localparam int DW       = 16;
    localparam int FB       = 200;
    localparam int LAT      = 2;
    localparam int N        = 5 * FB;
    localparam int BUSY_CYC = 1 + FB + LAT;
    localparam int BUDGET   = 20000;

`ifdef BLOCK_FILTER_CTRL_BYPASS_EN
    localparam bit BypassBuild = 1'b1;
`else
    localparam bit BypassBuild = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          flt_reset;
    logic [DW-1:0] flt_in0, flt_in_1, flt_in_2, flt_in_3, flt_in_4;
    logic [DW-1:0] flt_out0, flt_out_1, flt_out_2, flt_out_3, flt_out_4;
    logic          busy;
    logic          frame_done;
`ifdef BLOCK_FILTER_CTRL_BYPASS_EN
    logic          bypass;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] frameIn [N];
    logic [DW-1:0] expOut  [N];
    bit            fltIdentity = 1'b0;

    logic [DW-1:0] stubIn  [5];
    logic [DW-1:0] stubOut [5];
    logic [DW-1:0] stubPrev;

    block_filter_ctrl #(.DW(DW), .FRAME_BLOCKS(FB), .LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .flt_reset  (flt_reset),
        .flt_in0    (flt_in0),
        .flt_in_1   (flt_in_1),
        .flt_in_2   (flt_in_2),
        .flt_in_3   (flt_in_3),
        .flt_in_4   (flt_in_4),
        .flt_out0   (flt_out0),
        .flt_out_1  (flt_out_1),
        .flt_out_2  (flt_out_2),
        .flt_out_3  (flt_out_3),
        .flt_out_4  (flt_out_4),
`ifdef BLOCK_FILTER_CTRL_BYPASS_EN
        .bypass     (bypass),
`endif
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Block lanes in sample order: index 0 is the oldest sample (flt_in_4)
    always_comb begin
        stubIn[0] = flt_in_4;
        stubIn[1] = flt_in_3;
        stubIn[2] = flt_in_2;
        stubIn[3] = flt_in_1;
        stubIn[4] = flt_in0;
    end

    // Filter stand-in: one register stage, cleared by flt_reset
    always @(posedge clk or posedge flt_reset) begin
        if (flt_reset) begin
            for (int i = 0; i < 5; i++) stubOut[i] <= '0;
            stubPrev <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (fltIdentity) stubOut[i] <= stubIn[i];
                else stubOut[i] <= stubIn[i] + (((i == 0) ? stubPrev : stubIn[(i + 4) % 5]) >> 1);
            end
            stubPrev <= stubIn[4];
        end
    end

    assign flt_out_4 = stubOut[0];
    assign flt_out_3 = stubOut[1];
    assign flt_out_2 = stubOut[2];
    assign flt_out_1 = stubOut[3];
    assign flt_out0  = stubOut[4];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected output frame computed directly from the sample-level filter equation
    task automatic buildExpected(input bit identity, input bit byp);
        for (int n = 0; n < N; n++) begin
            if (byp || identity) expOut[n] = frameIn[n];
            else expOut[n] = frameIn[n] + ((n == 0) ? 16'h0000 : (frameIn[n-1] >> 1));
        end
    endtask

    // Push one frame in and pull it out, with given valid/ready probabilities (percent)
    task automatic applyStimulus(input int sProb, input int mProb, input bit byp,
                                 input bit laneChk, input int abortAt);
        int inIdx = 0, outIdx = 0, cyc = 0, busyCnt = 0, rstCnt = 0, doneCnt = 0;
        int lastBusy = -1, lastAcc = -1, firstValid = -1, laneBlk = 0, laneBad = 0, overlapBad = 0;
        logic [DW-1:0] heldData = '0;
        logic [DW-1:0] base;
        logic heldLast = 1'b0, fdPre;
        bit stalled = 1'b0, aborted = 1'b0;
`ifdef BLOCK_FILTER_CTRL_BYPASS_EN
        bypass = byp;
`endif
        while (outIdx < N && cyc < BUDGET && !aborted) begin
            @(negedge clk);
            cyc++;
            fdPre = frame_done;
            if (busy) begin busyCnt++; lastBusy = cyc; end
            if (flt_reset) rstCnt++;
            if (m_valid && firstValid < 0) firstValid = cyc;
            if (s_ready && (busy || m_valid)) overlapBad++;
            if (busy && m_valid) overlapBad++;
            if (laneChk && busy && {flt_in_4, flt_in_3, flt_in_2, flt_in_1, flt_in0} != '0) begin
                base = DW'(5 * laneBlk);
                if (flt_in_4 !== base || flt_in_3 !== base + 16'd1 || flt_in_2 !== base + 16'd2 ||
                    flt_in_1 !== base + 16'd3 || flt_in0 !== base + 16'd4) laneBad++;
                laneBlk++;
            end
            if (stalled) begin
                checkOutput("stall_valid", m_valid, 1);
                checkOutput("stall_data", m_data, heldData);
                checkOutput("stall_last", m_last, heldLast);
            end
            if (abortAt > 0 && busyCnt == abortAt) begin
                s_valid = 1'b0;
                #2 reset = 1'b1;
                #1;
                checkOutput("rst_s_ready", s_ready, 0);
                checkOutput("rst_m_valid", m_valid, 0);
                checkOutput("rst_m_last", m_last, 0);
                checkOutput("rst_m_data", m_data, 0);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_flt_reset", flt_reset, 1);
                checkOutput("rst_flt_in_4", flt_in_4, 0);
                checkOutput("rst_flt_in0", flt_in0, 0);
                @(negedge clk);
                reset = 1'b0;
                #1;
                checkOutput("rst_release_s_ready", s_ready, 1);
                checkOutput("rst_release_flt_reset", flt_reset, 0);
                aborted = 1'b1;
            end else begin
                if (inIdx < N) begin
                    s_data  = frameIn[inIdx];
                    s_valid = ($urandom_range(99) < sProb);
                    if (s_valid && s_ready) begin inIdx++; lastAcc = cyc; end
                end else begin
                    s_valid = 1'b0;
                end
                m_ready = ($urandom_range(99) < mProb);
                #1;
                if (fdPre || frame_done) doneCnt++;
                if (m_valid && m_ready) begin
                    checkOutput($sformatf("out_data[%0d]", outIdx), m_data, expOut[outIdx]);
                    checkOutput($sformatf("out_last[%0d]", outIdx), m_last, (outIdx == N - 1));
                    outIdx++;
                    stalled = 1'b0;
                end else begin
                    stalled  = m_valid;
                    heldData = m_data;
                    heldLast = m_last;
                end
            end
        end
        if (!aborted) begin
            checkOutput("frame_complete", outIdx, N);
            @(negedge clk);
            m_ready = 1'b0;
            if (frame_done) doneCnt++;
            checkOutput("frame_done_pulses", doneCnt, 1);
            checkOutput("ready_valid_overlap", overlapBad, 0);
            if (byp) begin
                checkOutput("bypass_busy_cycles", busyCnt, 0);
                checkOutput("bypass_flt_reset_cycles", rstCnt, 0);
                checkOutput("bypass_valid_after_load", firstValid, lastAcc + 1);
            end else begin
                checkOutput("busy_cycles", busyCnt, BUSY_CYC);
                checkOutput("flt_reset_cycles", rstCnt, 1);
                checkOutput("valid_after_busy", firstValid, lastBusy + 1);
                if (laneChk) begin
                    checkOutput("lane_blocks_seen", laneBlk, FB);
                    checkOutput("lane_order_errors", laneBad, 0);
                end
            end
        end
    endtask

    initial begin
        int v;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
`ifdef BLOCK_FILTER_CTRL_BYPASS_EN
        bypass  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("reset_s_ready", s_ready, 0);
        checkOutput("reset_m_valid", m_valid, 0);
        checkOutput("reset_m_last", m_last, 0);
        checkOutput("reset_m_data", m_data, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_frame_done", frame_done, 0);
        checkOutput("reset_flt_in_4", flt_in_4, 0);
        checkOutput("reset_flt_in0", flt_in0, 0);
        checkOutput("reset_flt_reset", flt_reset, 1);
        reset = 1'b0;
        #1;
        checkOutput("release_s_ready", s_ready, 1);
        checkOutput("release_flt_reset", flt_reset, 0);

        $display("[TB] ramp frame, identity taps (bypass when built with it)");
        for (int n = 0; n < N; n++) frameIn[n] = DW'(n);
        fltIdentity = 1'b1;
        buildExpected(1'b1, BypassBuild);
        applyStimulus(100, 100, BypassBuild, 1'b1, 0);

        $display("[TB] ramp frame, filter taps, lane order");
        fltIdentity = 1'b0;
        buildExpected(1'b0, 1'b0);
        applyStimulus(100, 100, 1'b0, 1'b1, 0);

        $display("[TB] impulse frame");
        for (int n = 0; n < N; n++) frameIn[n] = (n == 0) ? 16'h0100 : 16'h0000;
        buildExpected(1'b0, 1'b0);
        applyStimulus(100, 100, 1'b0, 1'b0, 0);

        $display("[TB] frame isolation");
        for (int n = 0; n < N; n++) frameIn[n] = 16'h7FFF;
        buildExpected(1'b0, 1'b0);
        applyStimulus(100, 100, 1'b0, 1'b0, 0);
        for (int n = 0; n < N; n++) frameIn[n] = 16'h0000;
        buildExpected(1'b0, 1'b0);
        applyStimulus(100, 100, 1'b0, 1'b0, 0);

        $display("[TB] backpressure on sine frame");
        for (int n = 0; n < N; n++) begin
            v = $rtoi(12000.0 * $sin(6.283185307179586 * real'(n) / 40.0));
            frameIn[n] = v[15:0];
        end
        buildExpected(1'b0, 1'b0);
        applyStimulus(50, 30, 1'b0, 1'b0, 0);

        $display("[TB] reset during RUN, then a full random frame");
        for (int n = 0; n < N; n++) frameIn[n] = DW'($urandom);
        applyStimulus(100, 100, 1'b0, 1'b0, 101);
        for (int n = 0; n < N; n++) frameIn[n] = DW'($urandom);
        buildExpected(1'b0, 1'b0);
        applyStimulus(100, 100, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
